median_stream: RTL and testbench
================================

Name: median_stream

Overview:
- Streaming sliding-window rank filter over a W-bit sample stream. Generalises the fixed 3-input combinational median to an odd window of N samples.
- Holds a window of the last N accepted samples and emits a pipelined result for every accepted sample once the window is full. The result is the median by default, or the min/max by mode select.
- Sits between a sample source and downstream image/signal processing; no backpressure.

Parameters:
- W, 8, sample width in bits (1..32)
- N, 5, window length. Must be odd, 3..9; other values fail elaboration.

Ports:
- clk  input  1  clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous clear of window fill and pipeline valids
- in_valid  input  1  in_data/mode are sampled when high
- in_data  input  W  new sample, unsigned
- mode  input  2  00 median, 01 min, 10 max, 11 median (reserved)
- out_valid  output  1  out_data holds a valid result this cycle
- out_data  output  W  selected rank of the window

Behaviour:
- Reset (async, rst=1):
  - window regs, fill count, pipeline regs, out_data all go to 0; out_valid goes to 0.
  - Outputs stay at these values until two edges after the first full-window sample.
- Window:
  - Shift register win[0..N-1], where win[0] is the newest.
  - On an edge with in_valid=1 and flush=0: win[0]<=in_data, win[i]<=win[i-1], and the oldest sample is discarded.
  - When in_valid=0, the window holds.
- Fill count:
  - fill saturates at N and increments on each accepted sample.
  - A sample "completes a window" when fill is N-1 or N at acceptance.
- Pipeline (throughput 1 sample/clock, latency 2 clocks):
  - S1, the edge that accepts the sample: window updated; v1<=completes-window; m1<=mode.
  - S2, next edge: rank[i] registered for each i. rank[i] = count of j!=i with win[j]<win[i], or win[j]==win[i] and j<i. This tie break makes ranks a permutation 0..N-1. Also registers v2<=v1, m2<=m1, and a copy of the window.
  - S3, next edge: out_data<=window element whose rank equals target; out_valid<=v2. Target is (N-1)/2 for median, 0 for min, N-1 for max.
  - Net result: a sample accepted at edge k produces its result at the outputs after edge k+2.
  - out_data holds its last value when out_valid=0.
- Gaps: in_valid low cycles insert bubbles. Each S1 edge with in_valid=0 sets v1<=0, so out_valid is not asserted for that slot.
- Flush (synchronous, priority over in_valid):
  - fill<=0; v1, v2, out_valid<=0.
  - A sample presented with flush is discarded.
  - Window contents need not be cleared; stale data is never emitted because fill restarts.
- Mode: sampled per sample and carried down the pipeline. Changing mode does not affect results already in flight.
- Reset mid-stream: everything is cleared immediately; in-flight results are lost; refill needs N new samples.
- Arithmetic: unsigned compares only. Rank counters are ceil(log2 N) bits. No overflow is possible.

Test Plan (W=8, N=5):
1. Fill and median: after reset, feed 10,50,30,20,40 on consecutive cycles, mode=00.
   - out_valid stays 0 for the first 4 samples.
   - out_data=30, out_valid=1 two edges after the 5th acceptance.
2. Slide and modes: continue with 60 (mode 00), 5 (mode 10), 90 (mode 01).
   - Windows are {50,30,20,40,60}, {30,20,40,60,5}, {20,40,60,5,90}.
   - Results: 40, then 60, then 5, on three consecutive cycles.
3. Ties and extremes: feed 7,7,7,3,9, then 255,0,255,0,255 (mode 00).
   - Results: 7, then the sliding results through the second burst, ending in 255.
   - All-equal window 0,0,0,0,0 gives 0.
4. Gaps: same data as scenario 1 with in_valid low for 2 cycles between each sample.
   - Single out_valid pulse carrying 30, two edges after the 5th acceptance.
   - out_data holds 30 afterwards.
5. Flush: feed 4 samples, then pulse flush together with in_valid=1 and data 99. Then feed 1,2,3,4,5.
   - 99 is discarded.
   - No out_valid until the 5th new sample; the result is 3.
6. Async reset: assert rst between clock edges while a full-window result is in flight.
   - out_valid=0 and out_data=0 immediately, without a clock edge.
   - The in-flight result never appears; refill behaves as in scenario 1.

Source files
------------

// File: rtl/median_stream.sv
// Streaming sliding-window rank filter: keeps the last N accepted samples and
// emits the median, min or max of each full window two clocks after acceptance.

// Rank of one window slot: number of other slots that sort strictly before it.
// Equal values are ordered by slot index, so the N ranks form a permutation.
module median_stream_rank #(
  parameter int W  = 8,
  parameter int N  = 5,
  parameter int I  = 0,
  parameter int RW = 3
) (
  input  logic [N-1:0][W-1:0] win_i,
  output logic [RW-1:0]       rank_o
);
  // count the slots that sort ahead of slot I
  always_comb begin
    rank_o = '0;
    for (int j = 0; j < N; j++)
      if (j != I && ((win_i[j] < win_i[I]) || (win_i[j] == win_i[I] && j < I)))
        rank_o = rank_o + RW'(1);
  end
endmodule

module median_stream #(
  parameter int W = 8,
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic [1:0]   mode,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  localparam int RW = $clog2(N);
  localparam int FW = $clog2(N + 1);

  generate
    if (N < 3 || N > 9 || (N % 2) == 0) begin : g_bad_n
      $error("median_stream: N must be odd and within 3..9");
    end
    if (W < 1 || W > 32) begin : g_bad_w
      $error("median_stream: W must be within 1..32");
    end
  endgenerate

  // stage 1: window and fill
  logic [N-1:0][W-1:0]  win_q, win_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic                 v1_q;
  logic [1:0]           m1_q;
  // stage 2: ranks plus a snapshot of the window they describe
  logic [N-1:0][RW-1:0] rank_d, rank_q;
  logic [N-1:0][W-1:0]  win2_q;
  logic                 v2_q;
  logic [1:0]           m2_q;
  // stage 3: output
  logic                 out_valid_q;
  logic [W-1:0]         out_data_q, sel_d;
  logic [RW-1:0]        target;

  logic accept, completes;
  assign accept    = in_valid & ~flush;
  // fill of N-1 or N before this sample means the window is full after it
  assign completes = fill_q >= FW'(N - 1);

  // next window contents and saturating fill count
  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    if (accept) begin
      win_d[0] = in_data;
      for (int i = 1; i < N; i++) win_d[i] = win_q[i-1];
      if (fill_q != FW'(N)) fill_d = fill_q + FW'(1);
    end
    if (flush) fill_d = '0;
  end

  // one rank unit per window slot
  generate
    for (genvar g = 0; g < N; g++) begin : g_lane
      median_stream_rank #(.W(W), .N(N), .I(g), .RW(RW)) u_rank (
        .win_i  (win_q),
        .rank_o (rank_d[g])
      );
    end
  endgenerate

  // stage 1 registers: accept sample, tag slot valid when it completes a window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q  <= '0;
      fill_q <= '0;
      v1_q   <= 1'b0;
      m1_q   <= 2'b00;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
      v1_q   <= accept & completes;
      m1_q   <= mode;
    end
  end

  // stage 2 registers: ranks, window snapshot, valid and mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rank_q <= '0;
      win2_q <= '0;
      v2_q   <= 1'b0;
      m2_q   <= 2'b00;
    end else begin
      rank_q <= rank_d;
      win2_q <= win_q;
      v2_q   <= v1_q & ~flush;
      m2_q   <= m1_q;
    end
  end

  // target rank from the mode carried with this slot; 11 behaves as median
  always_comb begin
    case (m2_q)
      2'b01:   target = '0;
      2'b10:   target = RW'(N - 1);
      default: target = RW'((N - 1) / 2);
    endcase
  end

  // ranks are a permutation, so exactly one slot matches and an OR-mux suffices
  always_comb begin
    sel_d = '0;
    for (int i = 0; i < N; i++)
      if (rank_q[i] == target) sel_d = sel_d | win2_q[i];
  end

  // stage 3 registers: data only moves on a valid slot, otherwise it holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= v2_q & ~flush;
      if (v2_q && !flush) out_data_q <= sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
endmodule

// File: tb/tb_median_stream.sv
// Directed and random stimulus for median_stream (W=8, N=5) checked against a
// queue-and-sort reference model of the sliding window.
module tb_median_stream;
  localparam int W = 8;
  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic [1:0]   mode;
  logic         out_valid;
  logic [W-1:0] out_data;

  int errors = 0;
  int checks = 0;

  // reference model state
  int mwin[$];        // accepted samples, newest at the front
  int fill;
  bit sv[2];          // results in flight: [0] accepted last edge, [1] the edge before
  int sd[2];
  bit ev;
  int ed;

  median_stream #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .mode      (mode),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pick(int m);
    int s[$];
    for (int i = 0; i < N; i++) s.push_back(mwin[i]);
    s.sort();
    if (m == 1) return s[0];
    if (m == 2) return s[N-1];
    return s[(N-1)/2];
  endfunction

  task automatic model_reset();
    mwin.delete();
    fill = 0;
    sv[0] = 0; sv[1] = 0;
    sd[0] = 0; sd[1] = 0;
    ev = 0;
    ed = 0;
  endtask

  // drive one cycle, advance the model across the edge, then compare outputs
  task automatic step(bit v, int d, int m, bit f);
    in_valid = v;
    in_data  = 8'(d);
    mode     = 2'(m);
    flush    = f;
    @(posedge clk);
    #1;
    if (f) begin
      fill = 0;
      sv[0] = 0; sv[1] = 0;
      ev = 0;
    end else begin
      ev = sv[1];
      if (sv[1]) ed = sd[1];
      sv[1] = sv[0]; sd[1] = sd[0];
      sv[0] = 0;
      if (v) begin
        mwin.push_front(d & 8'hff);
        if (mwin.size() > N) void'(mwin.pop_back());
        if (fill < N) fill++;
        if (fill == N) begin
          sv[0] = 1;
          sd[0] = pick(m);
        end
      end
    end
    chk("out_valid", out_valid, ev);
    chk("out_data", out_data, ed);
  endtask

  task automatic feed(int d, int m);
    step(1'b1, d, m, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 1'b0);
  endtask

  task automatic do_flush();
    step(1'b0, 0, 0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; mode = 2'b00;
    model_reset();
    #1;
    chk("reset_valid", out_valid, 0);
    chk("reset_data", out_data, 0);
    #3 rst = 1'b0;

    // fill and median, then slide with per-sample modes
    feed(10, 0); feed(50, 0); feed(30, 0); feed(20, 0); feed(40, 0);
    feed(60, 0);
    feed(5, 2);
    chk("s1_median", out_data, 30);
    chk("s1_valid", out_valid, 1);
    feed(90, 1);
    chk("s2_median", out_data, 40);
    idle();
    chk("s2_max", out_data, 60);
    idle();
    chk("s2_min", out_data, 5);
    idle();

    // ties and extremes
    feed(7, 0); feed(7, 0); feed(7, 0); feed(3, 0); feed(9, 0);
    feed(255, 0); feed(0, 0); feed(255, 0); feed(0, 0); feed(255, 0);
    idle(); idle();
    chk("s3_extreme", out_data, 255);
    for (int i = 0; i < 5; i++) feed(0, 0);
    idle(); idle();
    chk("s3_all_zero", out_data, 0);

    // gaps between samples
    do_flush();
    feed(10, 0); idle(); idle();
    feed(50, 0); idle(); idle();
    feed(30, 0); idle(); idle();
    feed(20, 0); idle(); idle();
    feed(40, 0); idle(); idle();
    chk("s4_gap_data", out_data, 30);
    chk("s4_gap_valid", out_valid, 1);
    idle(); idle();
    chk("s4_hold", out_data, 30);

    // flush discards the sample presented with it and restarts the fill
    feed(11, 0); feed(12, 0); feed(13, 0); feed(14, 0);
    step(1'b1, 99, 0, 1'b1);
    feed(1, 0); feed(2, 0); feed(3, 0); feed(4, 0); feed(5, 0);
    idle(); idle();
    chk("s5_flush", out_data, 3);

    // async reset with results in flight
    do_flush();
    feed(10, 0); feed(50, 0); feed(30, 0); feed(20, 0); feed(40, 0);
    feed(60, 0); feed(70, 0);
    #2 rst = 1'b1;
    #1;
    chk("s6_rst_valid", out_valid, 0);
    chk("s6_rst_data", out_data, 0);
    model_reset();
    #1 rst = 1'b0;
    idle(); idle(); idle();
    feed(10, 0); feed(50, 0); feed(30, 0); feed(20, 0); feed(40, 0);
    idle(); idle();
    chk("s6_refill", out_data, 30);

    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 255),
           $urandom_range(0, 3), $urandom_range(0, 31) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
